// File: rtl/fetch_pkg.sv
// Shared widths, constants and slot layout for the decoupled fetch stage.
package fetch_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int INSTR_W      = 32;

    // addi x0, x0, 0
    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] addr;
        logic [INSTR_W-1:0]      instr;
        logic                    filled;
    } fetch_slot_t;

endpackage

// File: rtl/fetch_buf.sv
// In-order fetch buffer: a slot is allocated when a request is accepted and
// filled when its response returns, so decode always sees program order.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               alloc_en,
    input  logic [XLEN-1:0]    alloc_addr,
    input  logic               fill_en,
    input  logic [INSTR_W-1:0] fill_instr,
    input  logic               pop_en,
    output logic [CW-1:0]      occ,
    output logic [CW-1:0]      pend,
    output logic               head_valid,
    output logic [XLEN-1:0]    head_addr,
    output logic [INSTR_W-1:0] head_instr
);

    logic [XLEN-1:0]    addr_q  [DEPTH];
    logic [INSTR_W-1:0] instr_q [DEPTH];
    logic [DEPTH-1:0]   filled_q;
    logic [PW-1:0]      alloc_q;
    logic [PW-1:0]      fill_q;
    logic [PW-1:0]      rd_q;
    logic [CW-1:0]      occ_q;
    logic [CW-1:0]      pend_q;

    // NOTE: payload storage has no reset; the filled bits and occ are reset,
    // and they alone decide whether a slot's contents are ever looked at.
    always_ff @(posedge clk) begin
        if (alloc_en) addr_q[alloc_q] <= alloc_addr;
        if (fill_en)  instr_q[fill_q] <= fill_instr;
    end

    // NOTE: state registers use non-blocking assignments so every update in
    // this block sees the pre-edge pointer values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            alloc_q  <= '0;
            fill_q   <= '0;
            rd_q     <= '0;
            occ_q    <= '0;
            pend_q   <= '0;
            filled_q <= '0;
        end else begin
            // alloc and fill never target the same slot: alloc takes a free
            // slot, fill takes the oldest allocated-unfilled one.
            if (alloc_en) begin
                alloc_q           <= alloc_q + 1'b1;
                filled_q[alloc_q] <= 1'b0;
            end
            if (fill_en) begin
                fill_q           <= fill_q + 1'b1;
                filled_q[fill_q] <= 1'b1;
            end
            if (pop_en) rd_q <= rd_q + 1'b1;
            occ_q  <= occ_q + CW'(alloc_en) - CW'(pop_en);
            pend_q <= pend_q + CW'(alloc_en) - CW'(fill_en);
        end
    end

    assign occ        = occ_q;
    assign pend       = pend_q;
    assign head_valid = (occ_q != '0) && filled_q[rd_q];
    assign head_addr  = addr_q[rd_q];
    assign head_instr = instr_q[rd_q];

endmodule

// File: rtl/stage_fetch_q.sv
// Decoupled instruction-fetch stage: owns the PC, issues in-order memory
// requests, and discards responses that belong to a stream killed by a redirect.
module stage_fetch_q
    import fetch_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEFAULT,
    parameter int              DEPTH        = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_addr,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [XLEN-1:0]    out_addr,
    output logic [XLEN-1:0]    out_addr_plus
);

    localparam int            CW        = $clog2(DEPTH + 1);
    localparam logic [CW:0]   DEPTH_LIM = (CW + 1)'(DEPTH);

    logic [XLEN-1:0]    pc_q;
    logic [CW-1:0]      drop_q;
    logic [CW-1:0]      drop_d;

    logic [CW-1:0]      buf_occ;
    logic [CW-1:0]      buf_pend;
    logic               head_valid;
    logic [XLEN-1:0]    head_addr;
    logic [INSTR_W-1:0] head_instr;

    logic [CW:0]        budget;
    logic               req_fire;
    logic               fill_en;
    logic               pop_en;

    // Slots in use plus stale responses still owed by memory must never
    // exceed DEPTH, so every returning response always has a home.
    assign budget         = {1'b0, buf_occ} + {1'b0, drop_q};
    assign imem_req_valid = !rst && !redirect_valid && (budget < DEPTH_LIM);
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign fill_en   = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
    assign pop_en    = out_valid && out_ready && !redirect_valid;

    // NOTE: every variable written here gets its default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        drop_d = drop_q;
        if (redirect_valid) begin
            // Everything still owed by memory becomes stale; a response
            // arriving this cycle settles one of those debts immediately.
            drop_d = buf_pend + drop_q - CW'(imem_rsp_valid);
        end else if (imem_rsp_valid && (drop_q != '0)) begin
            drop_d = drop_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= RESET_VECTOR;
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
            if (redirect_valid)
                pc_q <= redirect_addr;
            else if (req_fire)
                pc_q <= pc_q + XLEN'(4);
        end
    end

    fetch_buf #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .alloc_en   (req_fire),
        .alloc_addr (pc_q),
        .fill_en    (fill_en),
        .fill_instr (imem_rsp_instr),
        .pop_en     (pop_en),
        .occ        (buf_occ),
        .pend       (buf_pend),
        .head_valid (head_valid),
        .head_addr  (head_addr),
        .head_instr (head_instr)
    );

    // Output fields come straight from buffer registers and read zero
    // whenever no instruction is presented.
    assign out_valid     = !rst && head_valid;
    assign out_instr     = out_valid ? head_instr : '0;
    assign out_addr      = out_valid ? head_addr : '0;
    assign out_addr_plus = out_valid ? head_addr + XLEN'(4) : '0;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && imem_rsp_valid && (drop_q == '0))
            assert (buf_pend != '0)
            else $error("stage_fetch_q: response arrived with no outstanding request");
    end
`endif

endmodule
